// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clock_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TIMEOUT
    } meter_state_t;

    localparam int unsigned CLK_HZ      = 50_000_000;
    localparam int unsigned DEF_TIMEOUT = 2 * CLK_HZ;
    localparam int unsigned DEF_CNT_W   = 32;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous level plus one-cycle rise/fall strobes.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   level;

    assign level = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_i};
            sync_d_q <= level;
        end
    end

    assign rise_o = level & ~sync_d_q;
    assign fall_o = ~level & sync_d_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and (with CLOCK_METER_DUTY_EN defined) high time of a slow input
// in CLOCK_50 cycles, presenting each result on a valid/ready interface.
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int unsigned      CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(DEF_TIMEOUT),
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic             timeout
);

    meter_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_q;
    logic             meas_valid_q;
    logic             overrun_q;
    logic             timeout_q;
    logic             rise;
    logic             fall;
    logic             load_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .clk_i (CLOCK_50),
        .rst_ni(reset_n),
        .sig_i (sig_in),
        .rise_o(rise),
        .fall_o(fall)
    );

    assign cnt_d  = cnt_q + CNT_W'(1);
    assign load_d = (state_q == MEASURE) && rise;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        cnt_q   <= '0;
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise on the last allowed cycle still counts as a valid period.
                    if (rise) begin
                        cnt_q <= '0;
                    end else if (cnt_d == TIMEOUT) begin
                        state_q   <= clock_meter_pkg::TIMEOUT;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                clock_meter_pkg::TIMEOUT: begin
                    if (rise) begin
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        state_q   <= MEASURE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load_d) begin
                period_q     <= cnt_d;
                meas_valid_q <= 1'b1;
                if (meas_valid_q && !meas_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (meas_valid_q && meas_ready) begin
                meas_valid_q <= 1'b0;
            end
        end
    end

    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;

`ifdef CLOCK_METER_DUTY_EN
    logic [CNT_W-1:0] hi_cap_q;
    logic [CNT_W-1:0] high_time_q;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            hi_cap_q    <= '0;
            high_time_q <= '0;
        end else begin
            if ((state_q == MEASURE) && fall) begin
                hi_cap_q <= cnt_d;
            end
            if (load_d) begin
                high_time_q <= hi_cap_q;
            end
        end
    end

    assign high_time = high_time_q;
`else
    // Fall strobe only matters when duty measurement is built in.
    logic unused_fall;
    assign unused_fall = fall;
    assign high_time   = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter (short TIMEOUT of 50 cycles).
module tb_clock_period_meter;

    localparam int CNT_W = 32;
`ifdef CLOCK_METER_DUTY_EN
    localparam int DUTY_ON = 1;
`else
    localparam int DUTY_ON = 0;
`endif

    logic             clk = 1'b0;
    logic             resetN;
    logic             sigIn;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] highTime;
    logic             measValid;
    logic             measReady;
    logic             overrun;
    logic             timeout;

    int total = 0;
    int bad = 0;
    int validCycles = 0;
    logic [CNT_W-1:0] lastPeriod = '0;
    logic [CNT_W-1:0] lastHigh = '0;

    clock_period_meter #(
        .CNT_W(CNT_W),
        .TIMEOUT(32'd50),
        .SYNC_STAGES(2)
    ) dut (
        .CLOCK_50(clk),
        .reset_n(resetN),
        .sig_in(sigIn),
        .period(period),
        .high_time(highTime),
        .meas_valid(measValid),
        .meas_ready(measReady),
        .overrun(overrun),
        .timeout(timeout)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold sigIn at a level for n cycles, recording any result seen while valid.
    task automatic applyStimulus(input logic level, input int n);
        sigIn = level;
        for (int i = 0; i < n; i++) begin
            tick();
            if (measValid) begin
                validCycles++;
                lastPeriod = period;
                lastHigh   = highTime;
            end
        end
    endtask

    task automatic applyReset();
        sigIn  = 1'b0;
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        validCycles = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [CNT_W-1:0] observed,
                               input logic [CNT_W-1:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic [CNT_W-1:0] expHigh(input int h);
        return (DUTY_ON != 0) ? CNT_W'(h) : '0;
    endfunction

    initial begin
        sigIn     = 1'b0;
        measReady = 1'b1;
        resetN    = 1'b0;

        // Reset state
        applyReset();
        checkOutput("reset_period", period, 0);
        checkOutput("reset_high", highTime, 0);
        checkOutput("reset_valid", {31'd0, measValid}, 0);
        checkOutput("reset_overrun", {31'd0, overrun}, 0);
        checkOutput("reset_timeout", {31'd0, timeout}, 0);

        // Square wave 4/4, always ready
        applyStimulus(1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 4);
            applyStimulus(1'b0, 4);
        end
        checkOutput("sq_results", validCycles, 4);
        checkOutput("sq_period", lastPeriod, 8);
        checkOutput("sq_high", lastHigh, expHigh(4));
        checkOutput("sq_overrun", {31'd0, overrun}, 0);

        // Duty cycle 3/7
        applyReset();
        applyStimulus(1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3);
            applyStimulus(1'b0, 7);
        end
        checkOutput("duty_results", validCycles, 3);
        checkOutput("duty_period", lastPeriod, 10);
        checkOutput("duty_high", lastHigh, expHigh(3));

        // Backpressure over two results
        measReady = 1'b0;
        applyReset();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        checkOutput("bp_first_valid", {31'd0, measValid}, 1);
        checkOutput("bp_first_overrun", {31'd0, overrun}, 0);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        checkOutput("bp_valid_held", {31'd0, measValid}, 1);
        checkOutput("bp_period", period, 8);
        checkOutput("bp_overrun", {31'd0, overrun}, 1);
        measReady = 1'b1;
        tick();
        measReady = 1'b0;
        checkOutput("bp_valid_drop", {31'd0, measValid}, 0);
        checkOutput("bp_overrun_sticky", {31'd0, overrun}, 1);

        // Timeout after a single rise
        measReady = 1'b1;
        applyReset();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 48);
        checkOutput("to_before", {31'd0, timeout}, 0);
        applyStimulus(1'b0, 1);
        checkOutput("to_asserted", {31'd0, timeout}, 1);
        checkOutput("to_no_result", validCycles, 0);
        applyStimulus(1'b0, 10);
        checkOutput("to_held", {31'd0, timeout}, 1);
        applyStimulus(1'b1, 4);
        checkOutput("to_cleared", {31'd0, timeout}, 0);
        checkOutput("to_partial_no_result", validCycles, 0);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        checkOutput("to_recover_results", validCycles, 1);
        checkOutput("to_recover_period", lastPeriod, 8);
        checkOutput("to_recover_high", lastHigh, expHigh(4));
        checkOutput("to_recover_timeout", {31'd0, timeout}, 0);

        // New result lands on the handshake cycle
        measReady = 1'b0;
        applyReset();
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 2);
        measReady = 1'b1;
        tick();
        measReady = 1'b0;
        checkOutput("col_valid", {31'd0, measValid}, 1);
        checkOutput("col_overrun", {31'd0, overrun}, 0);
        checkOutput("col_period", period, 8);
        measReady = 1'b1;
        tick();
        checkOutput("col_valid_drop", {31'd0, measValid}, 0);

        // Reset in the middle of a period
        measReady = 1'b0;
        applyReset();
        applyStimulus(1'b0, 3);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 4);
            applyStimulus(1'b0, 4);
        end
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 2);
        checkOutput("mid_pre_overrun", {31'd0, overrun}, 1);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        checkOutput("mid_period", period, 0);
        checkOutput("mid_high", highTime, 0);
        checkOutput("mid_valid", {31'd0, measValid}, 0);
        checkOutput("mid_overrun", {31'd0, overrun}, 0);
        checkOutput("mid_timeout", {31'd0, timeout}, 0);
        measReady   = 1'b1;
        validCycles = 0;
        applyStimulus(1'b0, 2);
        applyStimulus(1'b1, 4);
        applyStimulus(1'b0, 4);
        checkOutput("mid_first_rise", validCycles, 0);
        applyStimulus(1'b1, 4);
        checkOutput("mid_second_rise", validCycles, 1);
        checkOutput("mid_period_after", lastPeriod, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
